// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder
//   Receive-side decoder for a PWM line. The asynchronous input is passed
//   through a synchronizer. For each period, the block measures the number of
//   cycles from one rising edge to the next, and how many of those cycles were
//   high. Each finished measurement is posted with a one-cycle valid strobe.
//   If no rising edge arrives within TIMEOUT cycles, the line is flagged as
//   stuck, and the level it is stuck at is recorded.
//
// Parameters
//   CNT_W        width of the internal counters and of the result outputs
//   SYNC_STAGES  depth of the input synchronizer (must be 2 or more)
//   TIMEOUT      cycles without a rising edge before stuck is raised
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   en           measurement enable
//   pwm_in       asynchronous PWM input
//   period_cnt   cycles in the last full period (rise to next rise)
//   high_cnt     cycles the synchronized line was high within that period
//   meas_valid   one-cycle pulse: period_cnt/high_cnt were just updated
//   stuck        no rising edge has been seen for TIMEOUT cycles
//   stuck_level  synchronized line level at the moment stuck was raised
// ---------------------------------------------------------------------------
module pwm_duty_decoder #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;

  logic [CNT_W-1:0] ctr_q, ctr_d;
  logic [CNT_W-1:0] hctr_q, hctr_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, stuck_d, level_d;
  logic             timeout_hit;

  // Input synchronizer plus one-cycle delay for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  assign s           = sync_q[SYNC_STAGES-1];
  assign rise        = s & ~s_d;
  assign timeout_hit = (ctr_q == TIMEOUT_C);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter and result logic
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    hctr_d   = hctr_q;
    period_d = period_cnt;
    high_d   = high_cnt;
    valid_d  = 1'b0;
    stuck_d  = stuck;
    level_d  = stuck_level;

    if (!en) begin
      // Dropping enable abandons any partial measurement and clears stuck.
      // The last published results are kept.
      state_d = IDLE;
      ctr_d   = '0;
      hctr_d  = '0;
      stuck_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          ctr_d   = '0;
          hctr_d  = '0;
          stuck_d = 1'b0;
        end

        // Throw away the partial period that is in progress; the first
        // rise only starts a measurement.
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            ctr_d   = ONE_C;
            hctr_d  = ONE_C;
          end else if (timeout_hit) begin
            stuck_d = 1'b1;
            level_d = s;
            ctr_d   = '0;
          end else begin
            ctr_d = ctr_q + ONE_C;
          end
        end

        // A rise takes priority over a timeout that lands on the same
        // cycle, so a period of exactly TIMEOUT is still published.
        MEAS: begin
          if (rise) begin
            period_d = ctr_q;
            high_d   = hctr_q;
            valid_d  = 1'b1;
            stuck_d  = 1'b0;
            ctr_d    = ONE_C;
            hctr_d   = ONE_C;
          end else if (timeout_hit) begin
            stuck_d = 1'b1;
            level_d = s;
            ctr_d   = '0;
            hctr_d  = '0;
            state_d = ARM;
          end else begin
            ctr_d  = ctr_q + ONE_C;
            hctr_d = hctr_q + CNT_W'(s);
          end
        end

        default: begin
          state_d = IDLE;
          ctr_d   = '0;
          hctr_d  = '0;
        end
      endcase
    end
  end

  // Counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q       <= '0;
      hctr_q      <= '0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      hctr_q      <= hctr_d;
      period_cnt  <= period_d;
      high_cnt    <= high_d;
      meas_valid  <= valid_d;
      stuck       <= stuck_d;
      stuck_level <= level_d;
    end
  end

endmodule
